mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle MIPS control FSM's load/store/fetch accesses.
//  Accepts one word request at a time (read or write) from the control/datapath side.
//  Services it from an internal word array after a fixed LATENCY, then pulses Done.
//  Replaces the fixed FETCH_MEM_DELAY wait states with an explicit Req/Done handshake.
// PARAMETERS
//  DEPTH    256  number of 32-bit words in the array (power of 2)
//  LATENCY  3    cycles from request acceptance to Done (>=1)
//  ADDR_W   8    word-index width, = $clog2(DEPTH)
// PORTS
//  Clk       in   1   single clock, rising edge
//  Reset_n   in   1   asynchronous, active-low reset
//  Req       in   1   request strobe; sampled only in IDLE
//  wr        in   1   1 = write, 0 = read; qualified by Req
//  Addr      in   32  byte address; word index = Addr[ADDR_W+1:2]
//  WData     in   32  write data; sampled with Req
//  RData     out  32  read data; valid when Done=1, held until next read completes
//  Busy      out  1   1 from the cycle after acceptance until Done is deasserted
//  Done      out  1   one-cycle completion pulse
//  AlignErr  out  1   only with MEM_ALIGN_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=IDLE; Busy=0, Done=0, RData=0, AlignErr=0, counter=0.
//  The array contents are not reset.
//  FSM states and transitions:
//   - IDLE: if Req=1, latch wr/Addr/WData, load counter with LATENCY-1, and go to WAIT.
//   - WAIT: decrement counter each cycle; when counter==0, go to RESP.
//   - RESP: Done=1 for exactly this cycle.
//     - read: RData <= mem[idx], registered on entry.
//     - write: mem[idx] <= WData, committed at the RESP edge.
//     - Then return to IDLE.
//  LATENCY=1: WAIT lasts one cycle, so Done asserts 2 cycles after the Req edge.
//   Generally Done asserts LATENCY+1 cycles after the accepting edge.
//  Busy=1 in WAIT and RESP, 0 in IDLE.
//  Req while Busy: ignored and not queued; the initiator must re-issue after Done.
//  Req in the same cycle as Done (RESP): ignored; accepted at the earliest in the next IDLE cycle.
//  Addr wrap-around: bits above ADDR_W+1 are discarded, so the index is taken modulo DEPTH.
//   No error is raised for out-of-range addresses.
//  Addr[1:0] is ignored (word access) unless MEM_ALIGN_CHECK_EN is defined.
//  A write does not alter RData. A read after a write to the same index returns the new data.
//  Reset mid-operation: the transaction is aborted, a pending write is NOT committed,
//   and Done is never pulsed.
//  wr, Addr and WData are don't-care outside the Req-accept cycle (latched copies are used).
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//   - Addr[1:0]!=0 at acceptance sets AlignErr=1 together with Done.
//   - The write is suppressed; a read returns RData=32'h0.
//   - AlignErr clears when Done clears.
//  MEM_ALIGN_CHECK_EN undefined:
//   - The AlignErr port is absent.
//   - Addr[1:0] is ignored and the access proceeds normally.
// STRUCTURE
//  Package mips_mem_pkg:
//   - mem_state_t enum {IDLE, WAIT, RESP}.
//   - WORD_W=32 and the default DEPTH/LATENCY constants.
//  Sub-module mem_word_array: synchronous 1R1W word array (DEPTH x 32), written and read
//   only in RESP.
//  Top module: FSM, latency counter and request latches.
// TESTING
//  1. Reset mid-WAIT:
//     - stimulus: write issued; drop Reset_n on the next cycle; release; read the same index.
//     - response: old contents; Done never pulsed for the aborted write; Busy=0 immediately on reset.
//  2. Write then read:
//     - stimulus: Req,wr=1,Addr=0x10,WData=0xDEADBEEF; then Req,wr=0,Addr=0x10.
//     - response: each Done 4 cycles after acceptance (LATENCY=3); RData=0xDEADBEEF.
//  3. Busy ignore:
//     - stimulus: read Addr=0x0 (contains 0x11111111); during WAIT pulse Req,wr=1,Addr=0x0,WData=0xFFFFFFFF.
//     - response: ignored; RData=0x11111111; a later read still returns 0x11111111.
//  4. Wrap-around:
//     - stimulus: write 0xA5A5A5A5 to Addr=0x400 (DEPTH=256).
//     - response: a read of Addr=0x0 returns 0xA5A5A5A5.
//  5. LATENCY=1 build:
//     - stimulus: back-to-back Req held high.
//     - response: Done every 3rd cycle (accept, WAIT, RESP); no request accepted in RESP.
//  6. MEM_ALIGN_CHECK_EN build:
//     - stimulus: write Addr=0x13.
//     - response: AlignErr=1 with Done; a read of Addr=0x10 shows contents unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the multicycle MIPS memory responder.
// Imported by mem_word_array and mem_responder.
package mips_mem_pkg;

    localparam int WORD_W          = 32;
    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    function automatic logic addr_misaligned(input logic [1:0] byte_off);
        return |byte_off;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Synchronous 1R1W word array with a registered read port.
// Only the read-data register is reset; the storage itself is not.
module mem_word_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_en_i,
    input  logic              rd_clr_i,
    input  logic [ADDR_W-1:0] rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_idx_i,
    input  logic [WORD_W-1:0] wr_data_i
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_q;

    // NOTE: storage has no reset so it maps onto RAM; contents survive Reset_n.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_clr_i ? '0 : mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Req/Done memory responder: IDLE -> WAIT (LATENCY cycles) -> RESP (Done pulse).
// Optional MEM_ALIGN_CHECK_EN adds the AlignErr output and suppresses misaligned accesses.
module mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Req,
    input  logic              wr,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WData,
    output logic [31:0]       RData,
    output logic              Busy,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              Done,
    output logic              AlignErr
`else
    output logic              Done
`endif
);

    localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              busy_q;
    logic              done_q;

    logic accept;
    logic misalign;
    logic rd_en;
    logic wr_en;
    logic addr_unused;

    assign accept = (state_q == IDLE) && Req;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (Req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == RESP);
            if (accept) begin
                wr_q    <= wr;
                idx_q   <= Addr[ADDR_W+1:2];
                wdata_q <= WData;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;
    logic align_err_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            misalign_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            if (accept) begin
                misalign_q <= addr_misaligned(Addr[1:0]);
            end
            align_err_q <= (state_d == RESP) && misalign_q;
        end
    end

    assign misalign    = misalign_q;
    assign AlignErr    = align_err_q;
    assign addr_unused = |{1'b0, Addr[31:ADDR_W+2]};
`else
    assign misalign    = 1'b0;
    assign addr_unused = |{Addr[31:ADDR_W+2], Addr[1:0]};
`endif

    // Read data lands on the edge entering RESP; a write commits on the edge leaving it.
    assign rd_en = (state_q == WAIT) && (cnt_q == '0) && !wr_q;
    assign wr_en = (state_q == RESP) && wr_q && !misalign;

    mem_word_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i     (Clk),
        .rst_ni    (Reset_n),
        .rd_en_i   (rd_en),
        .rd_clr_i  (misalign),
        .rd_idx_i  (idx_q),
        .rd_data_o (RData),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx_q),
        .wr_data_i (wdata_q)
    );

    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table of accesses plus hand-written corner sequences.
// A second instance built with LATENCY=1 covers back-to-back requests.
module tb_mem_responder;

    localparam int LAT   = 3;
    localparam int LIMIT = 20;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Req, wr;
    logic [31:0] Addr, WData, RData;
    logic        Busy, Done;

    logic        req1, wr1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        busy1, done1;

`ifdef MEM_ALIGN_CHECK_EN
    logic        AlignErr, align1;
`endif

    always #5 Clk = ~Clk;

    mem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Req      (Req),
        .wr       (wr),
        .Addr     (Addr),
        .WData    (WData),
        .RData    (RData),
        .Busy     (Busy),
`ifdef MEM_ALIGN_CHECK_EN
        .Done     (Done),
        .AlignErr (AlignErr)
`else
        .Done     (Done)
`endif
    );

    mem_responder #(.DEPTH(256), .LATENCY(1)) dut_l1 (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Req      (req1),
        .wr       (wr1),
        .Addr     (addr1),
        .WData    (wdata1),
        .RData    (rdata1),
        .Busy     (busy1),
`ifdef MEM_ALIGN_CHECK_EN
        .Done     (done1),
        .AlignErr (align1)
`else
        .Done     (done1)
`endif
    );

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    vec_t        vecs [8];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Called just after a negedge; returns at the negedge after the accepting edge.
    task automatic start_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp, input string name);
        Req   = 1'b1;
        wr    = w;
        Addr  = a;
        WData = d;
        sb_q.push_back(exp);
        tick();
        Req   = 1'b0;
        wr    = 1'($urandom);
        Addr  = $urandom;
        WData = $urandom;
        check({name, "_busy_wait"}, {31'b0, Busy}, 32'd1);
    endtask

    task automatic wait_done(input string name, input int start_n, input bit exp_align,
                             input bit req_in_resp);
        int          n;
        logic [31:0] exp;
        n = start_n;
        while (!Done && n < LIMIT) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, LAT + 1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
        check({name, "_rdata"}, RData, exp);
`ifdef MEM_ALIGN_CHECK_EN
        check({name, "_alignerr"}, {31'b0, AlignErr}, {31'b0, exp_align});
`else
        if (exp_align) $display("note: %s alignment case not built", name);
`endif
        if (req_in_resp) begin
            Req  = 1'b1;
            wr   = 1'b0;
            Addr = 32'h10;
        end
        tick();
        Req = 1'b0;
        check({name, "_done_pulse"}, {31'b0, Done}, 32'd0);
        check({name, "_busy_idle"}, {31'b0, Busy}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check({name, "_alignerr_clr"}, {31'b0, AlignErr}, 32'd0);
`endif
    endtask

    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input string name);
        start_req(w, a, d, exp, name);
        wait_done(name, 1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, "wr_10"};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, "rd_10"};
        vecs[2] = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'hDEAD_BEEF, "wr_00"};
        vecs[3] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'hDEAD_BEEF, "wr_3fc"};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, "rd_00"};
        vecs[5] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, "rd_3fc"};
        vecs[6] = '{1'b0, 32'hFFFF_F7FC, 32'h0,         32'hCAFE_F00D, "rd_wrap_top"};
        vecs[7] = '{1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'hCAFE_F00D, "wr_44"};

        Reset_n = 1'b0;
        Req = 1'b0; wr = 1'b0; Addr = '0; WData = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        tick();
        tick();
        check("reset_busy",  {31'b0, Busy}, 32'd0);
        check("reset_done",  {31'b0, Done}, 32'd0);
        check("reset_rdata", RData, 32'd0);
        Reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            access(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].name);
        end
        access(1'b0, 32'h44, 32'h0, 32'h0BAD_F00D, "rd_44");

        // A request raised during WAIT must be dropped, not queued.
        start_req(1'b0, 32'h0, 32'h0, 32'h1111_1111, "busy_ign");
        Req = 1'b1; wr = 1'b1; Addr = 32'h0; WData = 32'hFFFF_FFFF;
        tick();
        Req = 1'b0;
        wait_done("busy_ign", 2, 1'b0, 1'b0);
        check("busy_ign_not_queued", {31'b0, Busy}, 32'd0);
        access(1'b0, 32'h0, 32'h0, 32'h1111_1111, "busy_ign_reread");

        access(1'b1, 32'h400, 32'hA5A5_A5A5, 32'h1111_1111, "wrap_wr");
        access(1'b0, 32'h0,   32'h0,         32'hA5A5_A5A5, "wrap_rd");

        // Req held during the RESP cycle only: must not start a new access.
        start_req(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, "resp_req");
        wait_done("resp_req", 1, 1'b0, 1'b1);
        tick();
        check("resp_req_still_idle", {31'b0, Busy}, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        start_req(1'b1, 32'h13, 32'hEEEE_EEEE, 32'hDEAD_BEEF, "align_wr");
        wait_done("align_wr", 1, 1'b1, 1'b0);
        start_req(1'b0, 32'h13, 32'h0, 32'h0, "align_rd");
        wait_done("align_rd", 1, 1'b1, 1'b0);
        access(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, "align_unchanged");
`else
        access(1'b0, 32'h13, 32'h0, 32'hDEAD_BEEF, "lsb_ignored");
`endif

        // Reset during WAIT aborts a write; storage keeps the old word.
        access(1'b1, 32'h20, 32'h1234_5678, RData, "pre_abort_wr");
        Req = 1'b1; wr = 1'b1; Addr = 32'h20; WData = 32'hBAD0_BAD0;
        tick();
        Req = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("abort_busy_now", {31'b0, Busy}, 32'd0);
        check("abort_rdata",    RData,         32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("abort_no_done", {31'b0, Done}, 32'd0);
        end
        Reset_n = 1'b1;
        tick();
        check("abort_idle", {31'b0, Busy}, 32'd0);
        access(1'b0, 32'h20, 32'h0, 32'h1234_5678, "abort_rd");

        // LATENCY=1 instance with Req held: accept, WAIT, RESP repeating.
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h8; wdata1 = 32'h7777_7777;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("l1_done_c%0d", k), {31'b0, done1}, {31'b0, (k % 3) == 2});
            check($sformatf("l1_busy_c%0d", k), {31'b0, busy1}, {31'b0, (k % 3) != 0});
        end
        wr1 = 1'b0;
        tick();
        req1 = 1'b0;
        tick();
        check("l1_rd_done",  {31'b0, done1}, 32'd1);
        check("l1_rd_rdata", rdata1, 32'h7777_7777);
        tick();
        check("l1_rd_idle",  {31'b0, busy1}, 32'd0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
